// File: rtl/xmit_pkg.sv
// Shared transmit-lane constants (K-character words and their ctrl flags)
// plus the arbiter state type and a small saturating-add helper.
package xmit_pkg;

  localparam logic [31:0] COMMA_WORD = 32'hC5BC_C5BC;
  localparam logic [3:0]  COMMA_CTRL = 4'b0101;
  localparam logic [31:0] SPACE_WORD = 32'hF7F7_F7F7;
  localparam logic [3:0]  SPACE_CTRL = 4'b1111;
  localparam logic [31:0] ABORT_WORD = 32'hE000_0000;
  localparam logic [3:0]  DATA_CTRL  = 4'b0000;
  localparam logic [7:0]  TAG_PREFIX = 8'hF5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG,
    ST_XFER,
    ST_ABORT
  } xmit_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/xmit_src_mux.sv
// Selects the head of the granted source and steers the block-transfer pop
// back to that source only.
module xmit_src_mux (
  input  logic        sel,
  input  logic        ev_empty,
  input  logic [31:0] ev_q,
  input  logic        ev_lst,
  input  logic        ft_empty,
  input  logic [31:0] ft_q,
  input  logic        ft_lst,
  input  logic        pop,
  output logic        sel_empty,
  output logic [31:0] sel_q,
  output logic        sel_lst,
  output logic        ev_pop,
  output logic        ft_pop
);

  assign sel_empty = sel ? ft_empty : ev_empty;
  assign sel_q     = sel ? ft_q     : ev_q;
  assign sel_lst   = sel ? ft_lst   : ev_lst;
  assign ev_pop    = pop && !sel;
  assign ft_pop    = pop &&  sel;

endmodule

// File: rtl/xmit_link_arbiter.sv
// Block-granular round-robin arbiter sharing one transceiver lane between the
// event and trigger-feature FIFOs; tags blocks, fills gaps with K idles.
module xmit_link_arbiter
  import xmit_pkg::*;
#(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024,
  parameter bit TAG_EN  = 1'b1
) (
  input  logic        coreclockout,
  input  logic        run,
  input  logic        busy,
  input  logic        ev_empty,
  input  logic [31:0] ev_q,
  input  logic        ev_fst,
  input  logic        ev_lst,
  output logic        ev_rdreq,
  input  logic        ft_empty,
  input  logic [31:0] ft_q,
  input  logic        ft_fst,
  input  logic        ft_lst,
  output logic        ft_rdreq,
  output logic [31:0] tx_datain,
  output logic [3:0]  tx_ctrlenable,
  output logic        active_src,
  output logic [15:0] blk_cnt,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  abort_cnt
);

  localparam int GW = $clog2(GAP + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  xmit_state_e   state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          active_src_q, active_src_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    abort_cnt_q, abort_cnt_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic [3:0]    tx_ctrl_q, tx_ctrl_d;

  logic        sel_empty, sel_lst, ack, xfer_pop;
  logic [31:0] sel_q;
  logic        ev_xfer_pop, ft_xfer_pop;
  logic        ev_orphan, ft_orphan, ev_elig, ft_elig;

  xmit_src_mux u_mux (
    .sel       (active_src_q),
    .ev_empty  (ev_empty),
    .ev_q      (ev_q),
    .ev_lst    (ev_lst),
    .ft_empty  (ft_empty),
    .ft_q      (ft_q),
    .ft_lst    (ft_lst),
    .pop       (xfer_pop),
    .sel_empty (sel_empty),
    .sel_q     (sel_q),
    .sel_lst   (sel_lst),
    .ev_pop    (ev_xfer_pop),
    .ft_pop    (ft_xfer_pop)
  );

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    stall_d      = stall_q;
    active_src_d = active_src_q;
    blk_cnt_d    = blk_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    tx_data_d    = COMMA_WORD;
    tx_ctrl_d    = COMMA_CTRL;
    xfer_pop     = 1'b0;
    ev_orphan    = 1'b0;
    ft_orphan    = 1'b0;
    ev_elig      = !ev_empty && ev_fst;
    ft_elig      = !ft_empty && ft_fst;
    ack          = !sel_empty && !busy;

    case (state_q)
      ST_IDLE: begin
        ev_orphan  = !ev_empty && !ev_fst;
        ft_orphan  = !ft_empty && !ft_fst;
        drop_cnt_d = sat_add8(drop_cnt_q, {1'b0, ev_orphan} + {1'b0, ft_orphan});
        if (gap_q != GW'(GAP)) gap_d = gap_q + 1'b1;
        // The grant cycle itself still puts a comma on the lane, so granting once
        // the counter reaches GAP-1 leaves exactly GAP commas before the block.
        if ((gap_q >= GW'(GAP - 1)) && (ev_elig || ft_elig)) begin
          active_src_d = (ev_elig && ft_elig) ? !active_src_q : ft_elig;
          stall_d      = '0;
          if (TAG_EN) begin
            state_d = ST_TAG;
          end else begin
            state_d   = ST_XFER;
            blk_cnt_d = blk_cnt_q + 16'd1;
          end
        end
      end
      ST_TAG: begin
        tx_data_d = {TAG_PREFIX, 7'b0, active_src_q, blk_cnt_q};
        tx_ctrl_d = DATA_CTRL;
        blk_cnt_d = blk_cnt_q + 16'd1;
        state_d   = ST_XFER;
      end
      ST_XFER: begin
        xfer_pop = ack;
        if (ack) begin
          tx_data_d = sel_q;
          tx_ctrl_d = DATA_CTRL;
          stall_d   = '0;
          if (sel_lst) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end
        end else begin
          tx_data_d = SPACE_WORD;
          tx_ctrl_d = SPACE_CTRL;
          if (sel_empty && !busy) begin
            stall_d = stall_q + 1'b1;
            if (stall_d == SW'(TIMEOUT)) state_d = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        tx_data_d   = ABORT_WORD;
        tx_ctrl_d   = DATA_CTRL;
        abort_cnt_d = sat_add8(abort_cnt_q, 2'd1);
        state_d     = ST_IDLE;
        gap_d       = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge coreclockout) begin
    if (!run) begin
      state_q      <= ST_IDLE;
      gap_q        <= GW'(GAP);
      stall_q      <= '0;
      active_src_q <= 1'b1;
      blk_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      abort_cnt_q  <= '0;
      tx_data_q    <= COMMA_WORD;
      tx_ctrl_q    <= COMMA_CTRL;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      stall_q      <= stall_d;
      active_src_q <= active_src_d;
      blk_cnt_q    <= blk_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_ctrl_q    <= tx_ctrl_d;
    end
  end

  assign ev_rdreq      = run && (ev_xfer_pop || ev_orphan);
  assign ft_rdreq      = run && (ft_xfer_pop || ft_orphan);
  assign tx_datain     = tx_data_q;
  assign tx_ctrlenable = tx_ctrl_q;
  assign active_src    = active_src_q;
  assign blk_cnt       = blk_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign abort_cnt     = abort_cnt_q;

endmodule

// File: tb/tb_xmit_link_arbiter.sv
// Bench for xmit_link_arbiter: show-ahead FIFO models feed both sources and a
// lane scoreboard matches every non-idle word against the expected stream.
module tb_xmit_link_arbiter;

  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] COMMA_W = 32'hC5BC_C5BC;
  localparam logic [31:0] SPACE_W = 32'hF7F7_F7F7;
  localparam logic [31:0] ABORT_W = 32'hE000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        run, busy;
  logic        ev_empty, ev_fst, ev_lst, ft_empty, ft_fst, ft_lst;
  logic [31:0] ev_q, ft_q;
  logic        ev_rdreq, ft_rdreq, active_src;
  logic [31:0] tx_datain;
  logic [3:0]  tx_ctrlenable;
  logic [15:0] blk_cnt;
  logic [7:0]  drop_cnt, abort_cnt;

  xmit_link_arbiter #(.GAP(GAP), .TIMEOUT(TIMEOUT), .TAG_EN(1'b1)) dut (
    .coreclockout (clk),
    .run          (run),
    .busy         (busy),
    .ev_empty     (ev_empty),
    .ev_q         (ev_q),
    .ev_fst       (ev_fst),
    .ev_lst       (ev_lst),
    .ev_rdreq     (ev_rdreq),
    .ft_empty     (ft_empty),
    .ft_q         (ft_q),
    .ft_fst       (ft_fst),
    .ft_lst       (ft_lst),
    .ft_rdreq     (ft_rdreq),
    .tx_datain    (tx_datain),
    .tx_ctrlenable(tx_ctrlenable),
    .active_src   (active_src),
    .blk_cnt      (blk_cnt),
    .drop_cnt     (drop_cnt),
    .abort_cnt    (abort_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
  } word_t;

  typedef struct packed {
    logic run, busy, ev_e, ev_f, ft_e, ft_f, xev, xft;
  } vec_t;

  word_t       evq[$];
  word_t       ftq[$];
  logic [31:0] expq[$];
  vec_t        vt[8];

  int checks = 0, errors = 0;
  int comma_run = 0, space_cnt = 0, last_gap = 0, busy_pops = 0, space0 = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    ev_empty = (evq.size() == 0);
    {ev_q, ev_fst, ev_lst} = ev_empty ? 34'h0 : evq[0];
    ft_empty = (ftq.size() == 0);
    {ft_q, ft_fst, ft_lst} = ft_empty ? 34'h0 : ftq[0];
  endtask

  task automatic observe();
    logic [31:0] e;
    if (!mon_en) return;
    if (tx_datain === COMMA_W && tx_ctrlenable === 4'b0101) begin
      comma_run++;
    end else if (tx_datain === SPACE_W && tx_ctrlenable === 4'b1111) begin
      space_cnt++;
    end else begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL lane_unexpected got %h/%b expected idle", tx_datain, tx_ctrlenable);
      end else begin
        e = expq.pop_front();
        if (tx_datain !== e || tx_ctrlenable !== 4'b0000) begin
          errors++;
          $display("FAIL lane_word got %h/%b expected %h/0000", tx_datain, tx_ctrlenable, e);
        end
        if (e[31:24] == 8'hF5) last_gap = comma_run;
      end
      comma_run = 0;
    end
  endtask

  // One clock: sample pops just before the edge, then observe the lane after it.
  task automatic tick();
    logic evp, ftp;
    #1;
    evp = ev_rdreq;
    ftp = ft_rdreq;
    if (busy && (evp === 1'b1 || ftp === 1'b1)) busy_pops++;
    @(posedge clk);
    #1;
    if (evp === 1'b1) begin
      if (evq.size() > 0) void'(evq.pop_front());
      else begin checks++; errors++; $display("FAIL ev_pop_empty got 1 expected 0"); end
    end
    if (ftp === 1'b1) begin
      if (ftq.size() > 0) void'(ftq.pop_front());
      else begin checks++; errors++; $display("FAIL ft_pop_empty got 1 expected 0"); end
    end
    observe();
    refresh();
  endtask

  task automatic push(input bit src, input logic [31:0] d, input logic f, input logic l);
    if (src) ftq.push_back('{d: d, f: f, l: l});
    else     evq.push_back('{d: d, f: f, l: l});
    refresh();
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && expq.size() > 0; i++) tick();
    chk(nm, expq.size(), 0);
  endtask

  task automatic do_reset();
    run = 1'b0;
    busy = 1'b0;
    evq.delete();
    ftq.delete();
    expq.delete();
    refresh();
    tick();
    tick();
    run = 1'b1;
    comma_run = 0;
    space_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // run, busy, ev_empty, ev_fst, ft_empty, ft_fst -> ev_rdreq, ft_rdreq (IDLE)
    vt[0] = '{run:0, busy:0, ev_e:0, ev_f:0, ft_e:0, ft_f:0, xev:0, xft:0};
    vt[1] = '{run:1, busy:0, ev_e:0, ev_f:0, ft_e:1, ft_f:0, xev:1, xft:0};
    vt[2] = '{run:1, busy:1, ev_e:0, ev_f:0, ft_e:0, ft_f:0, xev:1, xft:1};
    vt[3] = '{run:1, busy:0, ev_e:0, ev_f:1, ft_e:0, ft_f:0, xev:0, xft:1};
    vt[4] = '{run:1, busy:0, ev_e:0, ev_f:1, ft_e:0, ft_f:1, xev:0, xft:0};
    vt[5] = '{run:1, busy:0, ev_e:1, ev_f:0, ft_e:1, ft_f:0, xev:0, xft:0};
    vt[6] = '{run:0, busy:1, ev_e:0, ev_f:0, ft_e:0, ft_f:0, xev:0, xft:0};
    vt[7] = '{run:1, busy:1, ev_e:1, ev_f:1, ft_e:0, ft_f:0, xev:0, xft:1};

    // Reset state and quiet idle
    run = 1'b0;
    busy = 1'b0;
    refresh();
    tick();
    tick();
    chk("rst_tx_data", tx_datain, COMMA_W);
    chk("rst_tx_ctrl", {28'h0, tx_ctrlenable}, 32'h5);
    chk("rst_blk_cnt", {16'h0, blk_cnt}, 0);
    chk("rst_drop_cnt", {24'h0, drop_cnt}, 0);
    chk("rst_abort_cnt", {24'h0, abort_cnt}, 0);
    chk("rst_active_src", {31'h0, active_src}, 1);
    chk("rst_ev_rdreq", {31'h0, ev_rdreq}, 0);
    chk("rst_ft_rdreq", {31'h0, ft_rdreq}, 0);
    run = 1'b1;
    tick();
    tick();
    chk("idle_tx_data", tx_datain, COMMA_W);
    chk("idle_ev_rdreq", {31'h0, ev_rdreq}, 0);
    chk("idle_ft_rdreq", {31'h0, ft_rdreq}, 0);

    // Table: combinational pops in IDLE (orphans, eligibility, reset gating)
    for (int i = 0; i < 8; i++) begin
      run = 1'b0;
      busy = 1'b0;
      refresh();
      tick();
      run = vt[i].run;
      busy = vt[i].busy;
      ev_empty = vt[i].ev_e;
      ev_fst = vt[i].ev_f;
      ev_lst = 1'b0;
      ev_q = 32'h5A5A_0000 + i;
      ft_empty = vt[i].ft_e;
      ft_fst = vt[i].ft_f;
      ft_lst = 1'b0;
      ft_q = 32'hA5A5_0000 + i;
      #1;
      chk($sformatf("vec%0d_ev_rdreq", i), {31'h0, ev_rdreq}, {31'h0, vt[i].xev});
      chk($sformatf("vec%0d_ft_rdreq", i), {31'h0, ft_rdreq}, {31'h0, vt[i].xft});
    end

    // Single source-0 block with exact grant latency
    mon_en = 1'b1;
    do_reset();
    push(0, 32'h1111_1111, 1, 0);
    push(0, 32'h2222_2222, 0, 0);
    push(0, 32'h3333_3333, 0, 0);
    push(0, 32'h4444_4444, 0, 1);
    expq.push_back(32'hF500_0000);
    expq.push_back(32'h1111_1111);
    expq.push_back(32'h2222_2222);
    expq.push_back(32'h3333_3333);
    expq.push_back(32'h4444_4444);
    tick();
    tick();
    chk("blk_tag_latency", tx_datain, 32'hF500_0000);
    tick();
    chk("blk_first_data", tx_datain, 32'h1111_1111);
    drain("blk_drain", 20);
    tick();
    tick();
    tick();
    chk("blk_trailing_commas", {31'h0, comma_run >= GAP}, 1);
    chk("blk_cnt_one", {16'h0, blk_cnt}, 1);

    // Both sources ready together: source 0 first, then exactly GAP commas
    do_reset();
    push(0, 32'hA0A0_A0A1, 1, 0);
    push(0, 32'hA0A0_A0A2, 0, 1);
    push(1, 32'hB0B0_B0B1, 1, 0);
    push(1, 32'hB0B0_B0B2, 0, 1);
    expq.push_back(32'hF500_0000);
    expq.push_back(32'hA0A0_A0A1);
    expq.push_back(32'hA0A0_A0A2);
    expq.push_back(32'hF501_0001);
    expq.push_back(32'hB0B0_B0B1);
    expq.push_back(32'hB0B0_B0B2);
    drain("tie_drain", 40);
    chk("tie_gap", last_gap, GAP);
    chk("tie_active_src", {31'h0, active_src}, 1);
    chk("tie_blk_cnt", {16'h0, blk_cnt}, 2);

    // Busy for 3 cycles in the middle of a block
    do_reset();
    expq.push_back(32'hF500_0000);
    for (int i = 1; i <= 6; i++) begin
      push(0, 32'hC0C0_C000 + i, i == 1, i == 6);
      expq.push_back(32'hC0C0_C000 + i);
    end
    repeat (4) tick();
    busy = 1'b1;
    busy_pops = 0;
    space0 = space_cnt;
    repeat (3) tick();
    busy = 1'b0;
    drain("busy_drain", 30);
    chk("busy_spaces", space_cnt - space0, 3);
    chk("busy_no_pops", busy_pops, 0);

    // Source starves mid-block: timeout abort (busy holds the stall count)
    do_reset();
    push(0, 32'hD0D0_D001, 1, 0);
    push(0, 32'hD0D0_D002, 0, 0);
    expq.push_back(32'hF500_0000);
    expq.push_back(32'hD0D0_D001);
    expq.push_back(32'hD0D0_D002);
    drain("tmo_head_drain", 20);
    space0 = space_cnt;
    expq.push_back(ABORT_W);
    repeat (5) tick();
    busy = 1'b1;
    repeat (3) tick();
    busy = 1'b0;
    drain("tmo_abort_drain", TIMEOUT + 20);
    chk("tmo_spaces", space_cnt - space0, TIMEOUT + 3);
    tick();
    chk("tmo_abort_cnt", {24'h0, abort_cnt}, 1);
    push(0, 32'hD0D0_D003, 0, 0);
    push(0, 32'hD0D0_D004, 0, 0);
    push(0, 32'hD0D0_D005, 0, 1);
    repeat (6) tick();
    chk("tmo_drop_cnt", {24'h0, drop_cnt}, 3);
    chk("tmo_orphans_gone", evq.size(), 0);

    // Orphan counter saturates at 255
    do_reset();
    for (int i = 0; i < 260; i++) push(1, 32'h0BAD_0000 + i, 0, 0);
    repeat (270) tick();
    chk("drop_saturate", {24'h0, drop_cnt}, 255);
    chk("drop_all_popped", ftq.size(), 0);

    // run low mid-transfer, then a fresh block restarts blk_cnt
    do_reset();
    expq.push_back(32'hF500_0000);
    for (int i = 1; i <= 6; i++) begin
      push(0, 32'hE1E1_E100 + i, i == 1, i == 6);
      expq.push_back(32'hE1E1_E100 + i);
    end
    repeat (4) tick();
    run = 1'b0;
    #1;
    chk("runlow_ev_rdreq", {31'h0, ev_rdreq}, 0);
    chk("runlow_ft_rdreq", {31'h0, ft_rdreq}, 0);
    evq.delete();
    expq.delete();
    refresh();
    tick();
    chk("runlow_tx_data", tx_datain, COMMA_W);
    chk("runlow_tx_ctrl", {28'h0, tx_ctrlenable}, 32'h5);
    chk("runlow_blk_cnt", {16'h0, blk_cnt}, 0);
    run = 1'b1;
    push(0, 32'hF1F1_0001, 1, 0);
    push(0, 32'hF1F1_0002, 0, 1);
    expq.push_back(32'hF500_0000);
    expq.push_back(32'hF1F1_0001);
    expq.push_back(32'hF1F1_0002);
    drain("restart_drain", 20);
    chk("restart_blk_cnt", {16'h0, blk_cnt}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
